// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : useq_pkg
// Description : Shared constants for the microsequencer: opcodes, state IDs,
//               next-state-select encodings and control-word field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package useq_pkg;

    // Control-word geometry
    localparam int CW_W        = 25;
    localparam int CW_NSSEL_HI = 6;
    localparam int CW_NSSEL_LO = 5;
    localparam int CW_DBIN_HI  = 4;
    localparam int CW_DBIN_LO  = 0;

    // Next-state select encodings
    typedef enum logic [1:0] {
        NS_DIRECT  = 2'b00,
        NS_DECODE1 = 2'b01,
        NS_DECODE2 = 2'b10,
        NS_COND    = 2'b11
    } nssel_e;

    // Opcodes
    localparam int OP_LDR_RR = 0;
    localparam int OP_STR_RR = 1;
    localparam int OP_OP_RR  = 2;
    localparam int OP_POP    = 3;
    localparam int OP_PUSH   = 4;
    localparam int OP_BRZ    = 5;
    localparam int OP_LDR_RM = 6;
    localparam int OP_STR_RM = 7;
    localparam int OP_OP_RM  = 8;
    localparam int OP_TEST   = 9;

    // State IDs
    localparam int START0 = 0;
    localparam int ABDM1  = 1;
    localparam int ADRM1  = 5;
    localparam int BRZZ1  = 9;
    localparam int LDRM1  = 10;
    localparam int STRM1  = 11;
    localparam int OPRM1  = 12;
    localparam int TEST1  = 14;
    localparam int LDRR1  = 15;
    localparam int STRR1  = 16;
    localparam int OPRR1  = 17;
    localparam int POPR1  = 19;
    localparam int PUSH1  = 21;
    localparam int TRAP   = 31;

endpackage : useq_pkg
`default_nettype wire

// File: rtl/useq_decode.sv
`default_nettype none
// ============================================================================
// Module      : useq_decode
// Description : Combinational opcode/addressing-mode map. Returns the target
//               state and an illegal flag for either dispatch level.
// Revision    : 1.0 - initial release
// ============================================================================
module useq_decode
    import useq_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [1:0]        amode_i,
    input  logic              second_i,   // 0: first-level, 1: second-level
    output logic [ADDR_W-1:0] state_o,
    output logic              illegal_o
);

    // Two-level dispatch table; anything unmapped is flagged illegal
    always_comb begin
        state_o   = '0;
        illegal_o = 1'b0;
        if (!second_i) begin
            case (opcode_i)
                OP_W'(OP_LDR_RR): state_o = ADDR_W'(LDRR1);
                OP_W'(OP_STR_RR): state_o = ADDR_W'(STRR1);
                OP_W'(OP_OP_RR):  state_o = ADDR_W'(OPRR1);
                OP_W'(OP_POP):    state_o = ADDR_W'(POPR1);
                OP_W'(OP_PUSH):   state_o = ADDR_W'(PUSH1);
                OP_W'(OP_BRZ):    state_o = ADDR_W'(BRZZ1);
                OP_W'(OP_LDR_RM), OP_W'(OP_STR_RM),
                OP_W'(OP_OP_RM),  OP_W'(OP_TEST): begin
                    // Memory-operand forms first compute the address
                    case (amode_i)
                        2'd0:    state_o   = ADDR_W'(ABDM1);
                        2'd1:    state_o   = ADDR_W'(ADRM1);
                        default: illegal_o = 1'b1;
                    endcase
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (opcode_i)
                OP_W'(OP_LDR_RM): state_o   = ADDR_W'(LDRM1);
                OP_W'(OP_STR_RM): state_o   = ADDR_W'(STRM1);
                OP_W'(OP_OP_RM):  state_o   = ADDR_W'(OPRM1);
                OP_W'(OP_TEST):   state_o   = ADDR_W'(TEST1);
                default:          illegal_o = 1'b1;
            endcase
        end
    end

endmodule : useq_decode
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Next-state address generator for the control store. Keeps a
//               registered micro-PC, repeats on mem_wait, traps illegal
//               opcodes.
//               Build option USEQ_ILLEGAL_TRAP_EN: illegal decodes enter an
//               absorbing trap state and set a sticky flag; otherwise they
//               refetch state 0.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer
    import useq_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int OP_W       = 4,
    parameter int TRAP_STATE = 31
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CW_W-1:0]   controlword,
    input  logic [OP_W-1:0]   ir_opcode,
    input  logic [1:0]        ir_amode,
    input  logic              zflag,
    input  logic              mem_wait,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] upc,
    output logic              illegal
);

`ifdef USEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Where an illegal decode goes: trap state, or refetch from start0
    localparam logic [ADDR_W-1:0] ILL_TARGET = TRAP_EN ? ADDR_W'(TRAP_STATE) : '0;

    nssel_e            nssel;
    logic [4:0]        dbin;
    logic [ADDR_W-1:0] dec_state;
    logic              dec_illegal;
    logic [ADDR_W-1:0] upc_q;
    logic [ADDR_W-1:0] upc_d;
    logic              unused_cw;

    assign nssel     = nssel_e'(controlword[CW_NSSEL_HI:CW_NSSEL_LO]);
    assign dbin      = controlword[CW_DBIN_HI:CW_DBIN_LO];
    // Upper control-word bits drive the datapath, not sequencing
    assign unused_cw = &{1'b0, controlword[CW_W-1:CW_NSSEL_HI+1]};

    useq_decode #(
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_decode (
        .opcode_i  (ir_opcode),
        .amode_i   (ir_amode),
        .second_i  (nssel == NS_DECODE2),
        .state_o   (dec_state),
        .illegal_o (dec_illegal)
    );

    // Micro-PC register: loads the address presented to the control store
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upc_q <= '0;
        end else begin
            upc_q <= upc_d;
        end
    end

    // Next-state selection in priority order: reset, trap, wait, decode
    always_comb begin
        upc_d = upc_q;
        if (!reset_n) begin
            upc_d = '0;
        end else if (TRAP_EN && (upc_q == ADDR_W'(TRAP_STATE))) begin
            upc_d = ADDR_W'(TRAP_STATE);
        end else if (mem_wait) begin
            upc_d = upc_q;
        end else begin
            case (nssel)
                NS_DIRECT:  upc_d = ADDR_W'(dbin);
                NS_DECODE1,
                NS_DECODE2: upc_d = dec_illegal ? ILL_TARGET : dec_state;
                NS_COND:    upc_d = ADDR_W'({dbin[4:1], zflag});
                default:    upc_d = '0;
            endcase
        end
    end

`ifdef USEQ_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag: set when the trap state is loaded, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (upc_d == ADDR_W'(TRAP_STATE)) begin
            illegal_q <= 1'b1;
        end
    end
`endif

    // Outputs to the control store and status
    always_comb begin
        address = upc_d;
        upc     = upc_q;
`ifdef USEQ_ILLEGAL_TRAP_EN
        illegal = illegal_q;
`else
        illegal = 1'b0;
`endif
    end

endmodule : microsequencer
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Directed self-checking bench for microsequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] controlword;
    logic [3:0]  ir_opcode;
    logic [1:0]  ir_amode;
    logic        zflag;
    logic        mem_wait;
    logic [4:0]  address;
    logic [4:0]  upc;
    logic        illegal;

    int errors = 0;
    int checks = 0;

`ifdef USEQ_ILLEGAL_TRAP_EN
    localparam bit         TRAP_BUILD = 1'b1;
    localparam logic [4:0] ILL_ADDR   = 5'd31;
`else
    localparam bit         TRAP_BUILD = 1'b0;
    localparam logic [4:0] ILL_ADDR   = 5'd0;
`endif

    microsequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .controlword (controlword),
        .ir_opcode   (ir_opcode),
        .ir_amode    (ir_amode),
        .zflag       (zflag),
        .mem_wait    (mem_wait),
        .address     (address),
        .upc         (upc),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a control word and IR fields, then let combinational logic settle
    task automatic apply(input logic [1:0] ns, input logic [4:0] db,
                         input logic [3:0] op, input logic [1:0] am, input logic z);
        controlword = {18'h2A5A5, ns, db};
        ir_opcode   = op;
        ir_amode    = am;
        zflag       = z;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        mem_wait = 1'b0;
        apply(2'b00, 5'd23, 4'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_addr", 32'(address), 32'd0);
        check("rst_upc", 32'(upc), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Release with a zero word presented; first edge fetches start0
        apply(2'b00, 5'd0, 4'd0, 2'd0, 1'b0);
        reset_n = 1'b1;
        #1;
        step();
        apply(2'b00, 5'd23, 4'd0, 2'd0, 1'b0);
        check("start0_upc", 32'(upc), 32'd0);
        check("start0_addr", 32'(address), 32'd23);

        // Direct
        apply(2'b00, 5'b10100, 4'd0, 2'd0, 1'b0);
        check("direct_addr", 32'(address), 32'd20);
        step();
        check("direct_upc", 32'(upc), 32'd20);

        // First- and second-level decode
        apply(2'b01, 5'd0, 4'd0, 2'd0, 1'b0);
        check("dec1_ldrrr", 32'(address), 32'd15);
        apply(2'b01, 5'd0, 4'd8, 2'd1, 1'b0);
        check("dec1_oprm_am1", 32'(address), 32'd5);
        step();
        check("dec1_upc", 32'(upc), 32'd5);
        apply(2'b10, 5'd0, 4'd8, 2'd1, 1'b0);
        check("dec2_oprm", 32'(address), 32'd12);

        // Conditional
        apply(2'b11, 5'd6, 4'd0, 2'd0, 1'b1);
        check("cond_z1", 32'(address), 32'd7);
        apply(2'b11, 5'd6, 4'd0, 2'd0, 1'b0);
        check("cond_z0", 32'(address), 32'd6);

        // Decode table edges (combinational only, no edge taken)
        apply(2'b01, 5'd0, 4'd6, 2'd0, 1'b0);
        check("dec1_ldrm_am0", 32'(address), 32'd1);
        apply(2'b01, 5'd0, 4'd5, 2'd0, 1'b0);
        check("dec1_brz", 32'(address), 32'd9);
        apply(2'b01, 5'd0, 4'd4, 2'd0, 1'b0);
        check("dec1_push", 32'(address), 32'd21);
        apply(2'b01, 5'd0, 4'd9, 2'd2, 1'b0);
        check("dec1_am2_ill", 32'(address), 32'(ILL_ADDR));
        apply(2'b01, 5'd0, 4'd10, 2'd0, 1'b0);
        check("dec1_op10_ill", 32'(address), 32'(ILL_ADDR));
        apply(2'b01, 5'd0, 4'd15, 2'd0, 1'b0);
        check("dec1_op15_ill", 32'(address), 32'(ILL_ADDR));
        apply(2'b10, 5'd0, 4'd7, 2'd0, 1'b0);
        check("dec2_strm", 32'(address), 32'd11);
        apply(2'b10, 5'd0, 4'd9, 2'd0, 1'b0);
        check("dec2_test", 32'(address), 32'd14);
        apply(2'b10, 5'd0, 4'd5, 2'd0, 1'b0);
        check("dec2_op5_ill", 32'(address), 32'(ILL_ADDR));

        // mem_wait in state 19 repeats it; wait beats an illegal decode
        apply(2'b00, 5'd19, 4'd0, 2'd0, 1'b0);
        step();
        check("wait_pre_upc", 32'(upc), 32'd19);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) apply(2'b01, 5'd0, 4'd12, 2'd0, 1'b0);
            else        apply(2'b00, 5'd20, 4'd0, 2'd0, 1'b0);
            check("wait_addr", 32'(address), 32'd19);
            step();
            check("wait_upc", 32'(upc), 32'd19);
        end
        mem_wait = 1'b0;
        apply(2'b00, 5'd20, 4'd0, 2'd0, 1'b0);
        check("wait_release_addr", 32'(address), 32'd20);
        step();
        check("wait_release_upc", 32'(upc), 32'd20);

        // Asynchronous reset mid-program
        reset_n = 1'b0;
        #1;
        check("midrst_addr", 32'(address), 32'd0);
        check("midrst_upc", 32'(upc), 32'd0);
        step();
        reset_n = 1'b1;
        #1;

        // Illegal opcode 12
        apply(2'b01, 5'd0, 4'd12, 2'd0, 1'b0);
        check("ill_addr", 32'(address), 32'(ILL_ADDR));
        step();
        check("ill_upc", 32'(upc), 32'(ILL_ADDR));
        check("ill_flag", 32'(illegal), 32'(TRAP_BUILD));
        for (int i = 0; i < 10; i++) begin
            apply(2'b00, 5'd3, 4'd0, 2'd0, 1'b0);
            check("trap_hold_addr", 32'(address), TRAP_BUILD ? 32'd31 : 32'd3);
            check("trap_hold_flag", 32'(illegal), 32'(TRAP_BUILD));
            step();
        end
        reset_n = 1'b0;
        #1;
        check("trap_rst_addr", 32'(address), 32'd0);
        check("trap_rst_flag", 32'(illegal), 32'd0);
        check("trap_rst_upc", 32'(upc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_microsequencer
`default_nettype wire

// File: doc/microsequencer.md
# microsequencer

Next-state address generator for the microprogrammed controller. Sits directly upstream of the control store. Each cycle it turns the current 25-bit control word (`nssel`, `dbin` fields), the latched instruction register fields and the zero flag into the 5-bit control-store address. It keeps a registered micro-PC, holds on memory wait, and traps illegal opcodes.

## Interface
- `ADDR_W`, 5, control-store address width (state ID).
- `OP_W`, 4, instruction opcode width.
- `TRAP_STATE`, 31, state ID of the illegal-instruction trap.
- `clock`  in  1  rising-edge clock, shared with the control store.
- `reset_n`  in  1  asynchronous, active-low reset.
- `controlword`  in  25  current control word from the control store. Bits [6:5] are `nssel`; bits [4:0] are `dbin`.
- `ir_opcode`  in  OP_W  opcode field of the latched instruction register.
- `ir_amode`  in  2  addressing-mode field of the latched instruction register.
- `zflag`  in  1  ALU zero flag, sampled combinationally.
- `mem_wait`  in  1  memory not ready; repeat the current microinstruction.
- `address`  out  ADDR_W  next state ID, driven combinationally to the control store.
- `upc`  out  ADDR_W  registered state ID of the control word now presented.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- `nssel` = 00, direct: `address` = `dbin`.
- `nssel` = 01, first-level decode on `ir_opcode`:
  - 0 (LDR_RR) → 15; 1 (STR_RR) → 16; 2 (OP_RR) → 17; 3 (POP) → 19; 4 (PUSH) → 21; 5 (BRZ) → 9.
  - 6–9 (memory operand) dispatch on `ir_amode`: 0 → 1 (abdm1), 1 → 5 (adrm1). `ir_amode` 2 or 3 is illegal.
  - Opcodes 10–15 are illegal.
- `nssel` = 10, second-level dispatch after address computation: 6 → 10 (ldrm1); 7 → 11 (strm1); 8 → 12 (oprm1); 9 → 14 (test1). Any other opcode is illegal.
- `nssel` = 11, conditional: `address` = {`dbin`[4:1], `zflag`}. Example: brzz1 with `dbin` = 6 goes to 7 when Z = 1, else 6.
- Priority, highest first:
  1. reset → `address` = 0.
  2. `upc` == TRAP_STATE → `address` = TRAP_STATE (the trap state absorbs; the control word there is ignored).
  3. `mem_wait` → `address` = `upc`.
  4. Illegal decode → trap (see Configuration).
  5. Normal selection by `nssel`.
- On each rising edge, `upc` <= `address`. `upc` therefore tracks the state whose word the control store has just registered.
- `illegal` sets on the edge that loads TRAP_STATE. It clears only on reset.

## Timing
- Reset values: `upc` = 0, `illegal` = 0. `address` = 0 combinationally while `reset_n` is low, independent of the clock.
- Reset asserted mid-microprogram: everything returns to state 0 immediately. The first edge after release fetches start0.
- Issue rate: one microinstruction per cycle. `address` settles in the same cycle as `controlword`. Control-store latency is one edge.
- `mem_wait` held for N cycles repeats the current state N extra times. The datapath gates its side effects on `mem_wait`.
- `mem_wait` and an illegal decode in the same cycle: the wait wins. The trap is taken in the first non-wait cycle.
- `zflag` must be stable before the edge in any state with `nssel` = 11.

## Configuration
- `USEQ_ILLEGAL_TRAP_EN` defined: illegal decodes go to TRAP_STATE, set `illegal`, and hold until reset.
- `USEQ_ILLEGAL_TRAP_EN` undefined: illegal decodes go to state 0 (refetch). `illegal` is tied to 0 and TRAP_STATE has no absorbing behaviour.

## Structure
- Shared package `useq_pkg` holds:
  - Opcode constants and state-ID constants (START0 = 0, ABDM1 = 1, ADRM1 = 5, BRZZ1 = 9, LDRM1 = 10, STRM1 = 11, OPRM1 = 12, TEST1 = 14, LDRR1 = 15, STRR1 = 16, OPRR1 = 17, POPR1 = 19, PUSH1 = 21, TRAP = 31).
  - `nssel` encodings.
  - Control-word field bit positions.
- One sub-module, `useq_decode`: a purely combinational opcode/amode map returning {state, illegal} for both dispatch levels.

## Test plan
- Hold `reset_n` low for 3 cycles, then release → `address` = 0 during reset and `upc` = 0. After one edge, `upc` = 0 with start0 presented and `address` = 23.
- `nssel` = 00, `dbin` = 5'b10100 → `address` = 20; after the edge, `upc` = 20.
- `nssel` = 01 with `ir_opcode` = 0 → 15. With `ir_opcode` = 8 and `ir_amode` = 1 → 5. Then `nssel` = 10 with opcode 8 → 12.
- `nssel` = 11, `dbin` = 6: `zflag` = 1 → 7; `zflag` = 0 → 6.
- `nssel` = 01 with `ir_opcode` = 12:
  - Trap build → `address` = 31, `illegal` = 1 after the edge, held for 10 cycles. Assert `reset_n` → 0 and 0.
  - Non-trap build → `address` = 0 and `illegal` stays 0.
- In state 19, hold `mem_wait` for 3 cycles → `address` = 19 each cycle. The next cycle advances to 20.
